// File: rtl/ifetch_queue_if.sv
// Fetch-stage bundle: instruction memory read port, decode valid/ready, redirect.
// The fetch stage owns the master side; memory/decode/branch logic own the slave side.
// Signal names follow the memory and decode blocks this stage connects to.
interface ifetch_queue_if;
   logic [0:60] readAddr0;
   logic [0:63] readData0;
   logic        instValid;
   logic [0:31] inst;
   logic [0:63] instPc;
   logic        instReady;
   logic        redirect;
   logic [0:63] redirectPc;

   modport master (
      output readAddr0,
      input  readData0,
      output instValid,
      output inst,
      output instPc,
      input  instReady,
      input  redirect,
      input  redirectPc
   );

   modport slave (
      input  readAddr0,
      output readData0,
      input  instValid,
      input  inst,
      input  instPc,
      output instReady,
      output redirect,
      output redirectPc
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue; splits 64-bit doublewords into two BE words.
// Latency: head valid one cycle after reset/redirect release; 1 instr/cycle steady state.
// Backpressure: instReady low holds the head; fetch stalls once fewer than 2 slots are free.
module ifetch_queue #(
   parameter logic [0:63] RESET_PC = 64'h0,
   parameter int          DEPTH    = 4
) (
   input  logic           clk,
   input  logic           reset,
   ifetch_queue_if.master bus
);
   localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FETCH_LIMIT = (AW + 1)'(DEPTH - 2);
   localparam logic [0:63] START_PC    = {RESET_PC[0:61], 2'b00};

   logic [0:63]   fetch_pc;
   logic [0:31]   q_inst [DEPTH];
   logic [0:63]   q_pc   [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;

   logic          fetch;
   logic          pair;
   logic          pop;
   logic          not_empty;
   logic [AW:0]   push_n;

   // Fetch/pop decisions use the current count, before this cycle's pop.
   always_comb begin
      not_empty = (count != '0);
      fetch     = (count <= FETCH_LIMIT);
      pair      = ~fetch_pc[61];
      pop       = not_empty & bus.instReady;
      push_n    = '0;
      if (fetch) begin
         push_n = pair ? (AW + 1)'(2) : (AW + 1)'(1);
      end
   end

   // Control state: reset beats redirect; redirect drops everything and suppresses the push.
   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fetch_pc <= START_PC;
      end else if (bus.redirect) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         fetch_pc <= {bus.redirectPc[0:61], 2'b00};
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (fetch) begin
            // push_n of 2 wraps correctly in the low AW bits even when DEPTH is 2
            wr_ptr   <= wr_ptr + push_n[AW-1:0];
            fetch_pc <= fetch_pc + (pair ? 64'd8 : 64'd4);
         end
         count <= count + push_n - {{AW{1'b0}}, pop};
      end
   end

   // Queue storage: an even word address pushes both halves, an odd one only the second.
   always_ff @(posedge clk) begin
      if (!reset && !bus.redirect && fetch) begin
         if (pair) begin
            q_inst[wr_ptr]          <= bus.readData0[0:31];
            q_pc[wr_ptr]            <= fetch_pc;
            q_inst[wr_ptr + AW'(1)] <= bus.readData0[32:63];
            q_pc[wr_ptr + AW'(1)]   <= fetch_pc + 64'd4;
         end else begin
            q_inst[wr_ptr] <= bus.readData0[32:63];
            q_pc[wr_ptr]   <= fetch_pc;
         end
      end
   end

   // Head outputs are gated to zero while the queue is empty.
   always_comb begin
      bus.readAddr0 = fetch_pc[0:60];
      bus.instValid = not_empty;
      bus.inst      = '0;
      bus.instPc    = '0;
      if (not_empty) begin
         bus.inst   = q_inst[rd_ptr];
         bus.instPc = q_pc[rd_ptr];
      end
   end
endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch stage with a prefetch queue, sitting directly upstream of the single-cycle decode/execute core. It drives the instruction port of `mem` (64-bit doublewords, combinational read) and splits each doubleword into two big-endian 32-bit instructions. Instructions and their PCs go into a small FIFO, which decode drains through a valid/ready handshake. A redirect from the branch logic flushes the queue and restarts fetch at the target.

## Interface
- `RESET_PC`, default 0: fetch address after reset; bits [62:63] are ignored (forced 00).
- `DEPTH`, default 4: queue entries; must be a power of two and ≥ 2.

- `clk`  in  1: clock; all state updates on posedge.
- `reset`  in  1: synchronous, active-high reset.
- `readAddr0`  out  [0:60]: doubleword address to `mem` port 0; always equals `fetchPc[0:60]`.
- `readData0`  in  [0:63]: doubleword from `mem`, valid in the same cycle; word 0 is `[0:31]`, word 1 is `[32:63]`.
- `instValid`  out  1: queue not empty.
- `inst`  out  [0:31]: head instruction; 0 when empty.
- `instPc`  out  [0:63]: byte address of the head instruction; 0 when empty.
- `instReady`  in  1: decode accepts the head this cycle.
- `redirect`  in  1: flush and refetch.
- `redirectPc`  in  [0:63]: new fetch address; bits [62:63] are ignored.

## Operation
- **State**
  - `fetchPc` [0:63], word aligned, bits [62:63] always 00.
  - Queue of `DEPTH` entries {inst, pc}.
  - Read and write pointers, each `log2(DEPTH)` bits, wrapping mod `DEPTH`.
  - `count`, 0..`DEPTH`.
- **Reset** (priority 1): `count`=0, both pointers=0, `fetchPc`=`RESET_PC` with [62:63]=00. No push and no pop.
- **Redirect** (priority 2, when reset is low)
  - `count`=0 and pointers=0.
  - `fetchPc`=`redirectPc` with [62:63]=00.
  - No push. The head is discarded regardless of `instReady`; a same-cycle handshake counts as a completed transfer.
- **Pop**: occurs when `instValid & instReady`. The read pointer advances by 1.
- **Fetch/push**: occurs when `count` ≤ `DEPTH`-2, evaluated on the current `count` before any pop.
  - `fetchPc[61]`=0: push `readData0[0:31]` with pc=`fetchPc`, then `readData0[32:63]` with pc=`fetchPc`+4. `fetchPc` += 8.
  - `fetchPc[61]`=1: push only `readData0[32:63]` with pc=`fetchPc`. `fetchPc` += 4.
- **Count**: `count_next` = `count` + pushes − pop. Push and pop in the same cycle are both performed.
- `fetchPc` arithmetic is modulo 2^64; wrapping from 0xFFFF_FFFF_FFFF_FFF8 to 0 is legal.
- The queue never overflows, because a fetch needs ≥ 2 free slots. Popping when empty is impossible, because pop requires `instValid`.
- `inst`/`instPc` are combinational from the head entry, gated to 0 when `count`=0.
- **Queue ordering**: strict program order from the last redirect/reset. No instruction is duplicated or skipped.

## Timing
- **Reset values**: `instValid`=0, `inst`=0, `instPc`=0. `readAddr0`=`RESET_PC[0:60]`.
- **Latency**: the first cycle with reset low and an empty queue performs a fetch. `instValid` rises on the next edge, one cycle after reset or redirect.
- **Steady-state throughput**: 1 instruction/cycle with `instReady` held high. The queue refills 2 per fetch while pops drain 1 per cycle.
- **Redirect**: the cycle after redirect has `instValid`=0. The target instruction appears one cycle later. This gives a 2-cycle bubble from the redirect edge to a valid target.
- **Reset mid-operation**: behaves identically to redirect to `RESET_PC`. All queued entries are lost.
- **`instReady` low**: the head and its outputs stay stable until popped; fetch continues until `count` > `DEPTH`-2.

## Test plan
- Memory word at byte address A holds A[32:63] (so `inst` equals the low 32 bits of `instPc`); `instReady`=1 after reset; `RESET_PC`=0 → `instValid` rises 1 cycle after reset deassert; (`inst`,`instPc`) = (0,0),(4,4),(8,8)… one per cycle, no gaps after the first.
- `RESET_PC`=0x104 (odd word) → first entry is pc 0x104 with data word 1 only; next is 0x108, then 0x10C.
- `instReady`=0 for 10 cycles after reset → `count` settles at 4 (`DEPTH`=4), `readAddr0` stops advancing at 0x10>>3, `inst` stays 0. Release → 0,4,8,C,10 in order.
- While the queue holds 0x20..0x2C, pulse `redirect` with `redirectPc`=0x1003 → next cycle `instValid`=0. The following cycle `instPc`=0x1000, then 0x1004; no stale 0x2x entries appear.
- Assert `reset` while the queue is full → next cycle `instValid`=0, `inst`=0, `readAddr0`=`RESET_PC[0:60]`. Output then resumes from `RESET_PC`.
- `redirectPc`=0xFFFF_FFFF_FFFF_FFF8 → entries FFF8, FFFC, then pc 0 and 4 (wrap).
